// File: rtl/vga_pkg.sv
// Shared definitions for the vga framebuffer blocks: default geometry,
// coordinate width, the fill-engine state encoding and the command record.
package vga_pkg;
  localparam int COORD_W       = 16;
  localparam int FB_WIDTH_DEF  = 160;
  localparam int FB_HEIGHT_DEF = 120;

  typedef enum logic [1:0] {IDLE, CLIP, FILL, DONE} fill_state_e;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] w;
    logic [COORD_W-1:0] h;
    logic [7:0]         color;
  } rect_cmd_t;
endpackage

// File: rtl/rect_clip.sv
// Combinational clip of a latched rectangle against the framebuffer bounds;
// yields exclusive end coordinates, an empty flag and the first row's address.
module rect_clip
  import vga_pkg::*;
#(
  parameter int          FB_WIDTH  = FB_WIDTH_DEF,
  parameter int          FB_HEIGHT = FB_HEIGHT_DEF,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic [COORD_W-1:0] w,
  input  logic [COORD_W-1:0] h,
  output logic [COORD_W-1:0] x_end,
  output logic [COORD_W-1:0] y_end,
  output logic               empty,
  output logic [31:0]        row_base
);
  localparam logic [COORD_W:0] W_EXT = (COORD_W+1)'(FB_WIDTH);
  localparam logic [COORD_W:0] H_EXT = (COORD_W+1)'(FB_HEIGHT);

  logic [COORD_W:0] x_sum;
  logic [COORD_W:0] y_sum;

  always_comb begin
    // one extra bit so origin+size never wraps before the clamp
    x_sum    = {1'b0, x} + {1'b0, w};
    y_sum    = {1'b0, y} + {1'b0, h};
    x_end    = (x_sum > W_EXT) ? W_EXT[COORD_W-1:0] : x_sum[COORD_W-1:0];
    y_end    = (y_sum > H_EXT) ? H_EXT[COORD_W-1:0] : y_sum[COORD_W-1:0];
    empty    = (w == '0) || (h == '0) || ({1'b0, x} >= W_EXT) || ({1'b0, y} >= H_EXT);
    row_base = BASE_ADDR + 32'(y) * 32'(FB_WIDTH);
  end
endmodule

// File: rtl/vga_rect_fill.sv
// Rectangle fill engine: latches one command, clips it, then streams one byte
// write per unstalled cycle in raster order into the framebuffer CPU port.
module vga_rect_fill
  import vga_pkg::*;
#(
  parameter int          FB_WIDTH  = FB_WIDTH_DEF,
  parameter int          FB_HEIGHT = FB_HEIGHT_DEF,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        pclk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [15:0] cmd_x,
  input  logic [15:0] cmd_y,
  input  logic [15:0] cmd_w,
  input  logic [15:0] cmd_h,
  input  logic [7:0]  cmd_color,
  input  logic        wr_stall,
  output logic        cpu_wr,
  output logic [31:0] cpu_addr,
  output logic [7:0]  cpu_data,
  output logic        busy,
  output logic        done
);
  fill_state_e        state_q, state_d;
  rect_cmd_t          cmd_q, cmd_d;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic [COORD_W-1:0] x_end_q, x_end_d, y_end_q, y_end_d;
  logic [31:0]        row_base_q, row_base_d;
  logic               cpu_wr_q, cpu_wr_d;
  logic [31:0]        cpu_addr_q, cpu_addr_d;
  logic [7:0]         cpu_data_q, cpu_data_d;
  logic               cmd_ready_q, cmd_ready_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [COORD_W-1:0] clip_x_end, clip_y_end;
  logic               clip_empty;
  logic [31:0]        clip_row_base;

  rect_clip #(
    .FB_WIDTH (FB_WIDTH),
    .FB_HEIGHT(FB_HEIGHT),
    .BASE_ADDR(BASE_ADDR)
  ) u_clip (
    .x       (cmd_q.x),
    .y       (cmd_q.y),
    .w       (cmd_q.w),
    .h       (cmd_q.h),
    .x_end   (clip_x_end),
    .y_end   (clip_y_end),
    .empty   (clip_empty),
    .row_base(clip_row_base)
  );

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    x_d        = x_q;
    y_d        = y_q;
    x_end_d    = x_end_q;
    y_end_d    = y_end_q;
    row_base_d = row_base_q;
    cpu_wr_d   = 1'b0;
    cpu_addr_d = cpu_addr_q;
    cpu_data_d = cpu_data_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          cmd_d   = '{x: cmd_x, y: cmd_y, w: cmd_w, h: cmd_h, color: cmd_color};
          state_d = CLIP;
        end
      end
      CLIP: begin
        x_end_d    = clip_x_end;
        y_end_d    = clip_y_end;
        row_base_d = clip_row_base;
        x_d        = cmd_q.x;
        y_d        = cmd_q.y;
        state_d    = clip_empty ? DONE : FILL;
      end
      FILL: begin
        // address/data always track the pending pixel, even while stalled
        cpu_addr_d = row_base_q + 32'(x_q);
        cpu_data_d = cmd_q.color;
        if (!wr_stall) begin
          cpu_wr_d = 1'b1;
          if (x_q + COORD_W'(1) == x_end_q) begin
            if (y_q + COORD_W'(1) == y_end_q) begin
              state_d = DONE;
            end else begin
              x_d        = cmd_q.x;
              y_d        = y_q + COORD_W'(1);
              row_base_d = row_base_q + 32'(FB_WIDTH);
            end
          end else begin
            x_d = x_q + COORD_W'(1);
          end
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // ready stays low through the done pulse so accepts never overlap it
    cmd_ready_d = (state_q == IDLE) && (state_d == IDLE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cmd_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      x_end_q     <= '0;
      y_end_q     <= '0;
      row_base_q  <= '0;
      cpu_wr_q    <= 1'b0;
      cpu_addr_q  <= '0;
      cpu_data_q  <= '0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      x_q         <= x_d;
      y_q         <= y_d;
      x_end_q     <= x_end_d;
      y_end_q     <= y_end_d;
      row_base_q  <= row_base_d;
      cpu_wr_q    <= cpu_wr_d;
      cpu_addr_q  <= cpu_addr_d;
      cpu_data_q  <= cpu_data_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign cpu_wr    = cpu_wr_q;
  assign cpu_addr  = cpu_addr_q;
  assign cpu_data  = cpu_data_q;
  assign busy      = busy_q;
  assign done      = done_q;
endmodule

// File: tb/tb_vga_rect_fill.sv
// Bench for vga_rect_fill: two instances (160x120 at 0, 16x8 at FFFFFFFE) run
// the same commands; writes/done/ready are checked against a pixel-list model.
module tb_vga_rect_fill;
  localparam int          AW = 160, AH = 120;
  localparam logic [31:0] ABASE = 32'h0000_0000;
  localparam int          BW = 16, BH = 8;
  localparam logic [31:0] BBASE = 32'hFFFF_FFFE;
  localparam int          HN = 50000;

  logic        pclk = 1'b0, reset = 1'b1, cmd_valid = 1'b0, wr_stall = 1'b0;
  logic [15:0] cmd_x = '0, cmd_y = '0, cmd_w = '0, cmd_h = '0;
  logic [7:0]  cmd_color = '0;
  logic [1:0]  cmd_ready, cpu_wr, busy, done;
  logic [31:0] cpu_addr [2];
  logic [7:0]  cpu_data [2];

  vga_rect_fill #(.FB_WIDTH(AW), .FB_HEIGHT(AH), .BASE_ADDR(ABASE)) u_a (
    .pclk(pclk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready[0]),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h), .cmd_color(cmd_color),
    .wr_stall(wr_stall), .cpu_wr(cpu_wr[0]), .cpu_addr(cpu_addr[0]), .cpu_data(cpu_data[0]),
    .busy(busy[0]), .done(done[0]));

  vga_rect_fill #(.FB_WIDTH(BW), .FB_HEIGHT(BH), .BASE_ADDR(BBASE)) u_b (
    .pclk(pclk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready[1]),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h), .cmd_color(cmd_color),
    .wr_stall(wr_stall), .cpu_wr(cpu_wr[1]), .cpu_addr(cpu_addr[1]), .cpu_data(cpu_data[1]),
    .busy(busy[1]), .done(done[1]));

  always #5 pclk = ~pclk;

  typedef struct { int x; int y; int w; int h; logic [7:0] c; } rc_t;
  typedef struct { int cyc; logic [31:0] a; logic [7:0] dat; } wr_t;

  wr_t wq0[$], wq1[$];
  int  dq0[$], dq1[$], aq0[$], aq1[$];
  int  cyc = 0;
  bit  stall_h [HN];
  bit  rdy_h   [2][HN];
  bit  busy_h  [2][HN];
  int  n_chk = 0, n_err = 0;

  // edge index e: stall sampled at edge e, accept at edge e
  always @(posedge pclk) begin
    stall_h[cyc] <= wr_stall;
    if (!reset && cmd_valid && cmd_ready[0]) aq0.push_back(cyc);
    if (!reset && cmd_valid && cmd_ready[1]) aq1.push_back(cyc);
    cyc <= cyc + 1;
  end

  // outputs seen in the interval following edge cyc-1
  always @(negedge pclk) begin
    if (cpu_wr[0]) wq0.push_back('{cyc: cyc-1, a: cpu_addr[0], dat: cpu_data[0]});
    if (cpu_wr[1]) wq1.push_back('{cyc: cyc-1, a: cpu_addr[1], dat: cpu_data[1]});
    if (done[0]) dq0.push_back(cyc-1);
    if (done[1]) dq1.push_back(cyc-1);
    rdy_h[0][cyc-1]  <= cmd_ready[0];
    rdy_h[1][cyc-1]  <= cmd_ready[1];
    busy_h[0][cyc-1] <= busy[0];
    busy_h[1][cyc-1] <= busy[1];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input rc_t c);
    cmd_x = 16'(c.x); cmd_y = 16'(c.y); cmd_w = 16'(c.w); cmd_h = 16'(c.h); cmd_color = c.c;
  endtask

  task automatic issue(input rc_t c);
    int t = 0;
    while (cmd_ready != 2'b11 && t < 500) begin @(negedge pclk); t++; end
    if (t >= 500) chk("ready_timeout", 32'(cmd_ready), 32'd3);
    drive(c);
    cmd_valid = 1'b1;
    @(negedge pclk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_dones(input int mode, input int need);
    int t = 0, k = 0;
    bit seen = 1'b0;
    while (!(dq0.size() >= need && dq1.size() >= need) && t < 4000) begin
      @(negedge pclk);
      t++;
      case (mode)
        1: wr_stall = ($urandom_range(0, 99) < 35);
        2: begin
          if (!seen && cpu_wr[0]) begin seen = 1'b1; k = 2; end
          wr_stall = (k > 0);
          if (k > 0) k--;
        end
        default: wr_stall = 1'b0;
      endcase
    end
    wr_stall = 1'b0;
    if (t >= 4000) chk("done_timeout", 32'(dq0.size() + dq1.size()), 32'(2 * need));
    repeat (3) @(negedge pclk);
  endtask

  // model: clip by min(), list every pixel in raster order, place each write on
  // the next unstalled edge starting two edges after the accept
  task automatic verify(input int d, input rc_t c, input string tag);
    int W, H, xe, ye, ea, dn, e;
    logic [31:0] base;
    logic [31:0] ex[$];
    wr_t got[$];
    W = d ? BW : AW; H = d ? BH : AH; base = d ? BBASE : ABASE;
    xe = (c.x + c.w < W) ? c.x + c.w : W;
    ye = (c.y + c.h < H) ? c.y + c.h : H;
    if (!(c.w == 0 || c.h == 0 || c.x >= W || c.y >= H))
      for (int r = c.y; r < ye; r++)
        for (int col = c.x; col < xe; col++)
          ex.push_back(32'(longint'(base) + longint'(r) * W + col));
    if (d == 0) begin
      ea = (aq0.size() > 0) ? aq0.pop_front() : -1;
      dn = (dq0.size() > 0) ? dq0.pop_front() : -1;
      while (wq0.size() > 0 && (dn < 0 || wq0[0].cyc < dn)) got.push_back(wq0.pop_front());
    end else begin
      ea = (aq1.size() > 0) ? aq1.pop_front() : -1;
      dn = (dq1.size() > 0) ? dq1.pop_front() : -1;
      while (wq1.size() > 0 && (dn < 0 || wq1[0].cyc < dn)) got.push_back(wq1.pop_front());
    end
    chk($sformatf("%s%0d_accepted", tag, d), 32'(ea >= 0), 32'd1);
    if (ea < 0) return;
    chk($sformatf("%s%0d_busy_acc", tag, d), 32'(busy_h[d][ea]), 32'd1);
    chk($sformatf("%s%0d_nwr", tag, d), 32'(got.size()), 32'(ex.size()));
    e = ea + 2;
    for (int k = 0; k < ex.size() && k < got.size(); k++) begin
      while (stall_h[e] && e < HN - 2) e++;
      chk($sformatf("%s%0d_addr%0d", tag, d, k), got[k].a, ex[k]);
      chk($sformatf("%s%0d_data%0d", tag, d, k), 32'(got[k].dat), 32'(c.c));
      chk($sformatf("%s%0d_wcyc%0d", tag, d, k), 32'(got[k].cyc), 32'(e));
      e++;
    end
    chk($sformatf("%s%0d_done_cyc", tag, d), 32'(dn), 32'(e));
    chk($sformatf("%s%0d_busy_done", tag, d), 32'(busy_h[d][e]), 32'd0);
    chk($sformatf("%s%0d_rdy_done", tag, d), 32'(rdy_h[d][e]), 32'd0);
    chk($sformatf("%s%0d_rdy_after", tag, d), 32'(rdy_h[d][e+1]), 32'd1);
  endtask

  task automatic run(input rc_t c, input int mode, input string tag);
    issue(c);
    wait_dones(mode, 1);
    if (mode == 2) begin
      if (wq0.size() >= 2) chk({tag, "_stall_gap"}, 32'(wq0[1].cyc - wq0[0].cyc), 32'd3);
      else chk({tag, "_stall_nwr"}, 32'(wq0.size()), 32'd2);
    end
    verify(0, c, tag);
    verify(1, c, tag);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "watchdog");
  end

  initial begin
    rc_t c, c2;
    int t, cnt;
    repeat (2) @(negedge pclk);
    chk("rst_ready", 32'(cmd_ready), 32'd3);
    chk("rst_wr", 32'(cpu_wr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_addr", cpu_addr[0], 32'd0);
    chk("rst_data", 32'(cpu_data[0]), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge pclk);

    c = '{2, 3, 4, 2, 8'hA5};          run(c, 0, "basic");
    c = '{158, 119, 10, 10, 8'h11};    run(c, 0, "clip");
    c = '{160, 0, 5, 5, 8'h22};        run(c, 0, "offx");
    c = '{4, 4, 0, 7, 8'h33};          run(c, 0, "w0");
    c = '{4, 4, 7, 0, 8'h44};          run(c, 0, "h0");
    c = '{0, 0, 3, 1, 8'h55};          run(c, 2, "stall");
    c = '{0, 0, 4, 1, 8'h66};          run(c, 0, "wrap");
    c = '{65535, 65535, 65535, 65535, 8'h77}; run(c, 0, "maxc");
    c = '{150, 118, 65535, 65535, 8'h88};     run(c, 1, "bigwh");

    // command backpressure: second command held on the bus during a fill
    c  = '{1, 1, 6, 3, 8'h99};
    c2 = '{5, 2, 3, 2, 8'h3C};
    drive(c);
    cmd_valid = 1'b1;
    @(negedge pclk);
    drive(c2);
    t = 0;
    while (!(aq0.size() >= 2 && aq1.size() >= 2) && t < 500) begin @(negedge pclk); t++; end
    cmd_valid = 1'b0;
    if (aq0.size() >= 2 && dq0.size() >= 1) chk("bp_acc_gap", 32'(aq0[1] - dq0[0]), 32'd2);
    else chk("bp_second_acc", 32'(aq0.size()), 32'd2);
    wait_dones(0, 2);
    verify(0, c, "bp1_"); verify(1, c, "bp1_");
    verify(0, c2, "bp2_"); verify(1, c2, "bp2_");

    // reset during the third write of a 4x4 fill
    c = '{0, 0, 4, 4, 8'hE7};
    issue(c);
    cnt = 0; t = 0;
    while (cnt < 3 && t < 200) begin @(negedge pclk); t++; if (cpu_wr[0]) cnt++; end
    chk("mid_third_wr", 32'(cnt), 32'd3);
    reset = 1'b1;
    #1;
    chk("mid_rst_wr", 32'(cpu_wr), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ready", 32'(cmd_ready), 32'd3);
    repeat (2) @(negedge pclk);
    reset = 1'b0;
    repeat (4) @(negedge pclk);
    chk("mid_no_done", 32'(dq0.size() + dq1.size()), 32'd0);
    chk("mid_ready_after", 32'(cmd_ready), 32'd3);
    wq0.delete(); wq1.delete(); dq0.delete(); dq1.delete(); aq0.delete(); aq1.delete();
    c = '{3, 1, 5, 2, 8'h5A};          run(c, 0, "post_rst");

    for (int i = 0; i < 30; i++) begin
      c.x = $urandom_range(0, 1) ? int'($urandom_range(0, 20)) : int'($urandom_range(0, 170));
      c.y = $urandom_range(0, 1) ? int'($urandom_range(0, 10)) : int'($urandom_range(0, 125));
      c.w = $urandom_range(0, 12);
      c.h = $urandom_range(0, 6);
      c.c = 8'($urandom);
      run(c, 1, $sformatf("rnd%0d_", i));
    end

    chk("leftover", 32'(wq0.size() + wq1.size() + dq0.size() + dq1.size() + aq0.size() + aq1.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/vga_rect_fill.md
Name: vga_rect_fill

Overview:
Rectangle fill engine that sits directly upstream of the vga framebuffer's CPU write port. It accepts one fill command (origin, size, colour byte) over a valid/ready handshake. It clips the rectangle to the framebuffer bounds, then emits one byte write per cycle on cpu_wr/cpu_addr/cpu_data in raster order. bocks_top instantiates it in place of the tied-off cpu_* wires.

Parameters:
FB_WIDTH, 160, framebuffer width in pixels (bytes per row), 1..65535
FB_HEIGHT, 120, framebuffer height in rows, 1..65535
BASE_ADDR, 32'h00000000, byte address of pixel (0,0)

Ports:
pclk  input  1  pixel/system clock, all logic rising-edge
reset  input  1  asynchronous, active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  engine can accept a command
cmd_x  input  16  left column
cmd_y  input  16  top row
cmd_w  input  16  width in pixels
cmd_h  input  16  height in rows
cmd_color  input  8  fill byte
wr_stall  input  1  sink cannot take a write this cycle
cpu_wr  output  1  write strobe, one byte per asserted cycle
cpu_addr  output  32  byte address
cpu_data  output  8  byte data
busy  output  1  command in progress
done  output  1  one-cycle pulse after the last write of a command

Behaviour:
- One clock (pclk). reset is asynchronous and active-high. On reset: state IDLE, cmd_ready=1, cpu_wr=0, cpu_addr=0, cpu_data=0, busy=0, done=0. Reset mid-fill aborts with no done pulse. cpu_wr deasserts asynchronously.
- States: IDLE, CLIP, FILL, DONE.
- IDLE: cmd_ready=1, busy=0. A command is accepted when cmd_valid&&cmd_ready on a pclk edge (cycle N). Fields are latched and the engine goes to CLIP. cmd_ready=0 in all other states, so there are no back-to-back accepts.
- CLIP (cycle N+1, registered):
  - x_end = min(cmd_x+cmd_w, FB_WIDTH); y_end = min(cmd_y+cmd_h, FB_HEIGHT). Sums are computed 17-bit, so there is no wrap.
  - Empty if cmd_w==0, cmd_h==0, cmd_x>=FB_WIDTH or cmd_y>=FB_HEIGHT. Empty goes to DONE with zero writes. Otherwise go to FILL.
  - Load x=cmd_x, y=cmd_y, row_base=BASE_ADDR+cmd_y*FB_WIDTH. This is the only multiply, done once in the CLIP cycle; a constant-multiply is acceptable.
- FILL: first write appears in cycle N+2 if wr_stall=0.
  - Each cycle with wr_stall=0: cpu_wr=1, cpu_addr=row_base+x (32-bit, modulo 2^32), cpu_data=latched colour, then advance.
  - Advance: if x+1==x_end then x=cmd_x, y=y+1, row_base+=FB_WIDTH; else x=x+1.
  - After the write at (x_end-1, y_end-1), go to DONE.
  - Each cycle with wr_stall=1: cpu_wr=0, and x/y/row_base hold. cpu_addr/cpu_data show the pending write.
  - Total writes = (x_end-cmd_x)*(y_end-cmd_y), exactly, each address exactly once, in ascending address order.
- DONE: done=1 for exactly one cycle, busy=0 in that cycle, then IDLE. busy=1 in CLIP and FILL.
- cpu_wr is registered. Outputs are glitch-free from registers.
- wr_stall is ignored outside FILL.

Decomposition:
- Shared package vga_pkg:
  - state enum (IDLE/CLIP/FILL/DONE)
  - default FB_WIDTH/FB_HEIGHT constants, also used by the vga module
  - coord width constant COORD_W=16
- One natural sub-module: rect_clip. It is combinational and computes x_end, y_end, empty and the start row_base from the latched command. It is registered by the parent in CLIP.
- The walker and FSM stay in vga_rect_fill.

Test Plan:
- Basic fill: cmd x=2,y=3,w=4,h=2,color=8'hA5, FB 160x120 -> 8 writes at 482..485 then 642..645, all data A5. First cpu_wr 2 cycles after accept; done pulse the cycle after the last write.
- Clipping: x=158,y=119,w=10,h=10 -> exactly 2 writes, addrs 19198,19199. x=160,y=0,w=5,h=5 -> 0 writes, done 2 cycles after accept.
- Degenerate: w=0,h=7 and w=7,h=0 -> no cpu_wr, single done pulse, cmd_ready back to 1 the cycle after done.
- Stall: x=0,y=0,w=3,h=1 with wr_stall high for 2 cycles after the first write -> writes 0,1,2 with no skip or duplicate. Write 1 appears the cycle after stall drops.
- Backpressure on commands: cmd_valid held high with a second command during a busy fill -> second command is not accepted until IDLE and is then executed intact. BASE_ADDR=32'hFFFFFFFE, x=0,y=0,w=4,h=1 -> addrs FFFFFFFE, FFFFFFFF, 0, 1.
- Reset mid-fill: assert reset at write 3 of a 4x4 fill -> cpu_wr drops immediately, no done pulse. After release cmd_ready=1 and a new command runs normally.
